// File: rtl/cache_memory_nway_if.sv
// rtl/cache_memory_nway_if.sv - CPU request / memory interface bundle for cache_memory_nway
interface cache_memory_nway_if #(
    parameter int CPU_DATA_W = 32,
    parameter int ADDR_W     = 16,
    parameter int INDEX_W    = 4,
    parameter int LINE_WORDS = 4
);
    localparam int OFFSET_W = $clog2(LINE_WORDS) + $clog2(CPU_DATA_W / 8);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_W   = LINE_WORDS * CPU_DATA_W;

    logic [ADDR_W-1:0]          CPU_ADDR;
    logic                       SIG_CPU_RD;
    logic                       SIG_CPU_WR;
    logic [CPU_DATA_W-1:0]      CPU_OUT_DATA;
    logic [CPU_DATA_W/8-1:0]    CPU_B_VAL;
    logic [LINE_W-1:0]          MI_OUT_DATA;
    logic                       MI_SIG_RAM_ACK;
    logic                       ACK;
    logic                       SIG_RAM_RD;
    logic                       SIG_RAM_WR;
    logic [TAG_W+INDEX_W-1:0]   RAM_ADDR;
    logic [LINE_W-1:0]          MI_IN_DATA;
    logic [CPU_DATA_W-1:0]      CPU_IN_DATA;

    modport slave (
        input  CPU_ADDR, SIG_CPU_RD, SIG_CPU_WR, CPU_OUT_DATA, CPU_B_VAL,
        input  MI_OUT_DATA, MI_SIG_RAM_ACK,
        output ACK, SIG_RAM_RD, SIG_RAM_WR, RAM_ADDR, MI_IN_DATA, CPU_IN_DATA
    );

    modport master (
        output CPU_ADDR, SIG_CPU_RD, SIG_CPU_WR, CPU_OUT_DATA, CPU_B_VAL,
        output MI_OUT_DATA, MI_SIG_RAM_ACK,
        input  ACK, SIG_RAM_RD, SIG_RAM_WR, RAM_ADDR, MI_IN_DATA, CPU_IN_DATA
    );
endinterface

// File: rtl/cache_memory_nway.sv
// rtl/cache_memory_nway.sv - N-way set-associative cache controller, round-robin replacement
// Write-through/write-allocate by default; define CACHE_WRITE_BACK_EN for write-back with dirty bits.
module cache_memory_nway #(
    parameter int CPU_DATA_W = 32,
    parameter int ADDR_W     = 16,
    parameter int INDEX_W    = 4,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    cache_memory_nway_if.slave  bus
);
    localparam int BYTES    = CPU_DATA_W / 8;
    localparam int BYTE_OFF = $clog2(BYTES);
    localparam int OFFSET_W = $clog2(LINE_WORDS) + BYTE_OFF;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_W   = LINE_WORDS * CPU_DATA_W;
    localparam int SETS     = 1 << INDEX_W;
    localparam int WSEL_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_EVICT, S_FILL, S_UPDATE, S_WTHRU, S_DONE
    } state_t;

    state_t                 state;
    logic [TAG_W-1:0]       req_tag;
    logic [INDEX_W-1:0]     req_index;
    logic [WSEL_W-1:0]      req_word;
    logic [CPU_DATA_W-1:0]  req_data;
    logic [BYTES-1:0]       req_be;
    logic                   req_wr;
    logic [WAY_W-1:0]       sel_way;

    logic                   valid_mem [WAYS][SETS];
    logic [TAG_W-1:0]       tag_mem   [WAYS][SETS];
    logic [LINE_W-1:0]      data_mem  [WAYS][SETS];
    logic [WAY_W-1:0]       ptr_mem   [SETS];
`ifdef CACHE_WRITE_BACK_EN
    logic                   dirty_mem [WAYS][SETS];
`endif

    logic                   hit;
    logic [WAY_W-1:0]       hit_way;
    logic [WAY_W-1:0]       victim;
    logic                   found_free;
    logic [LINE_W-1:0]      cur_line;
    logic [LINE_W-1:0]      merged;
    logic [CPU_DATA_W-1:0]  rd_word;
    logic                   unused_addr_bits;

    // Only tag/index/word are latched; byte-offset bits never matter.
    assign unused_addr_bits = ^bus.CPU_ADDR;

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim     = ptr_mem[req_index];
        found_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_mem[w][req_index] && (tag_mem[w][req_index] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            // Lowest-numbered invalid way wins over the round-robin pointer.
            if (!valid_mem[w][req_index] && !found_free) begin
                found_free = 1'b1;
                victim     = WAY_W'(w);
            end
        end
    end

    always_comb begin
        cur_line = data_mem[sel_way][req_index];
        merged   = cur_line;
        rd_word  = '0;
        for (int wd = 0; wd < LINE_WORDS; wd++) begin
            if (WSEL_W'(wd) == req_word) begin
                rd_word = cur_line[wd*CPU_DATA_W +: CPU_DATA_W];
                for (int b = 0; b < BYTES; b++) begin
                    if (req_be[b]) begin
                        merged[wd*CPU_DATA_W + b*8 +: 8] = req_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state           <= S_IDLE;
            bus.ACK         <= 1'b0;
            bus.SIG_RAM_RD  <= 1'b0;
            bus.SIG_RAM_WR  <= 1'b0;
            bus.RAM_ADDR    <= '0;
            bus.MI_IN_DATA  <= '0;
            bus.CPU_IN_DATA <= '0;
            for (int s = 0; s < SETS; s++) begin
                ptr_mem[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_mem[w][s] <= 1'b0;
`ifdef CACHE_WRITE_BACK_EN
                    dirty_mem[w][s] <= 1'b0;
`endif
                end
            end
        end else begin
            bus.ACK <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.SIG_CPU_RD || bus.SIG_CPU_WR) begin
                        req_tag   <= bus.CPU_ADDR[ADDR_W-1 -: TAG_W];
                        req_index <= bus.CPU_ADDR[OFFSET_W +: INDEX_W];
                        req_word  <= WSEL_W'((bus.CPU_ADDR >> BYTE_OFF) & ADDR_W'(LINE_WORDS - 1));
                        req_data  <= bus.CPU_OUT_DATA;
                        req_be    <= bus.CPU_B_VAL;
                        req_wr    <= bus.SIG_CPU_WR;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        sel_way <= hit_way;
                        state   <= S_UPDATE;
                    end else begin
                        sel_way <= victim;
`ifdef CACHE_WRITE_BACK_EN
                        state   <= (valid_mem[victim][req_index] && dirty_mem[victim][req_index])
                                   ? S_EVICT : S_FILL;
`else
                        state   <= S_FILL;
`endif
                    end
                end
                S_EVICT: begin
                    if (!bus.SIG_RAM_WR) begin
                        bus.SIG_RAM_WR <= 1'b1;
                        bus.RAM_ADDR   <= {tag_mem[sel_way][req_index], req_index};
                        bus.MI_IN_DATA <= cur_line;
                    end else if (bus.MI_SIG_RAM_ACK) begin
                        bus.SIG_RAM_WR <= 1'b0;
                        state          <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (!bus.SIG_RAM_RD) begin
                        bus.SIG_RAM_RD <= 1'b1;
                        bus.RAM_ADDR   <= {req_tag, req_index};
                    end else if (bus.MI_SIG_RAM_ACK) begin
                        bus.SIG_RAM_RD               <= 1'b0;
                        data_mem[sel_way][req_index] <= bus.MI_OUT_DATA;
                        tag_mem[sel_way][req_index]  <= req_tag;
                        valid_mem[sel_way][req_index] <= 1'b1;
`ifdef CACHE_WRITE_BACK_EN
                        dirty_mem[sel_way][req_index] <= 1'b0;
`endif
                        ptr_mem[req_index] <= (WAYS == 1) ? '0 : ptr_mem[req_index] + 1'b1;
                        state              <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (!req_wr) begin
                        bus.CPU_IN_DATA <= rd_word;
                        state           <= S_DONE;
                    end else begin
                        data_mem[sel_way][req_index] <= merged;
`ifdef CACHE_WRITE_BACK_EN
                        dirty_mem[sel_way][req_index] <= 1'b1;
                        state                         <= S_DONE;
`else
                        bus.RAM_ADDR   <= {req_tag, req_index};
                        bus.MI_IN_DATA <= merged;
                        state          <= S_WTHRU;
`endif
                    end
                end
                S_WTHRU: begin
                    if (!bus.SIG_RAM_WR) begin
                        bus.SIG_RAM_WR <= 1'b1;
                    end else if (bus.MI_SIG_RAM_ACK) begin
                        bus.SIG_RAM_WR <= 1'b0;
                        state          <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.ACK <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_memory_nway.sv
// tb/tb_cache_memory_nway.sv - directed self-checking bench for cache_memory_nway
// Expectations follow CACHE_WRITE_BACK_EN when the macro is defined for the build.
module tb_cache_memory_nway;
    localparam logic [127:0] LINE_A  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h88888888};
    localparam logic [127:0] LINE_AW = {32'h44441111, 32'h33333333, 32'h22222222, 32'h88888888};
    localparam logic [127:0] LINE_B  = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
    localparam logic [127:0] LINE_C  = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
    localparam logic [127:0] LINE_D  = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
    localparam logic [127:0] LINE_E  = 128'hEEEE0003_EEEE0002_EEEE0001_EEEE0000;
    localparam logic [127:0] LINE_EW = 128'hEEEE0003_EEEE0002_EEEE0001_A5A5A5A5;
    localparam logic [127:0] LINE_F  = 128'hFFFF0003_FFFF0002_FFFF0001_FFFF0000;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   ack_cnt = 0;
    int   rd_rise = 0;
    int   wr_rise = 0;
    int   both_high = 0;
    logic rd_q = 1'b0;
    logic wr_q = 1'b0;
    int   lat;
    int   snap_rd, snap_wr, snap_ack;
    bit   ok;
    logic [127:0] line;

    always #5 CLK = ~CLK;

    cache_memory_nway_if #(.CPU_DATA_W(32), .ADDR_W(16), .INDEX_W(4), .LINE_WORDS(4)) bus ();

    cache_memory_nway #(
        .CPU_DATA_W(32), .ADDR_W(16), .INDEX_W(4), .WAYS(2), .LINE_WORDS(4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always @(posedge CLK) begin
        #1;
        if (bus.ACK) ack_cnt++;
        if (bus.SIG_RAM_RD && !rd_q) rd_rise++;
        if (bus.SIG_RAM_WR && !wr_q) wr_rise++;
        if (bus.SIG_RAM_RD && bus.SIG_RAM_WR) both_high++;
        rd_q = bus.SIG_RAM_RD;
        wr_q = bus.SIG_RAM_WR;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        @(negedge CLK);
        bus.SIG_CPU_RD   = rd;
        bus.SIG_CPU_WR   = wr;
        bus.CPU_ADDR     = addr;
        bus.CPU_OUT_DATA = data;
        bus.CPU_B_VAL    = be;
        @(negedge CLK);
        bus.SIG_CPU_RD   = 1'b0;
        bus.SIG_CPU_WR   = 1'b0;
    endtask

    // Edges after the sampling edge until ACK is seen; 0 on timeout.
    task automatic wait_ack(output int edges);
        int n = 1;
        while (!bus.ACK && n < 80) begin
            @(negedge CLK);
            n++;
        end
        edges = bus.ACK ? n - 1 : 0;
        if (!bus.ACK) check("ack_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_strobe(input bit is_wr, output bit seen);
        int n = 0;
        while (!(is_wr ? bus.SIG_RAM_WR : bus.SIG_RAM_RD) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        seen = is_wr ? bus.SIG_RAM_WR : bus.SIG_RAM_RD;
    endtask

    task automatic finish_serve(input bit is_wr, input logic [127:0] fill, input string tag);
        logic [11:0] a0;
        a0 = bus.RAM_ADDR;
        repeat (2) @(negedge CLK);
        check({tag, "_held"}, is_wr ? bus.SIG_RAM_WR : bus.SIG_RAM_RD, 1'b1);
        check({tag, "_addr_stable"}, bus.RAM_ADDR, a0);
        bus.MI_OUT_DATA    = fill;
        bus.MI_SIG_RAM_ACK = 1'b1;
        @(negedge CLK);
        bus.MI_SIG_RAM_ACK = 1'b0;
        check({tag, "_dropped"}, is_wr ? bus.SIG_RAM_WR : bus.SIG_RAM_RD, 1'b0);
    endtask

    task automatic serve(input bit is_wr, input logic [11:0] exp_addr, input logic [127:0] fill,
                         input string tag, output logic [127:0] seen_line);
        bit seen;
        wait_strobe(is_wr, seen);
        check({tag, "_strobe"}, seen, 1'b1);
        check({tag, "_ram_addr"}, bus.RAM_ADDR, exp_addr);
        seen_line = bus.MI_IN_DATA;
        finish_serve(is_wr, fill, tag);
    endtask

    initial begin
        bus.CPU_ADDR = '0; bus.SIG_CPU_RD = 1'b0; bus.SIG_CPU_WR = 1'b0;
        bus.CPU_OUT_DATA = '0; bus.CPU_B_VAL = '0;
        bus.MI_OUT_DATA = '0; bus.MI_SIG_RAM_ACK = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ack", bus.ACK, 1'b0);
        check("rst_ram_rd", bus.SIG_RAM_RD, 1'b0);
        check("rst_ram_wr", bus.SIG_RAM_WR, 1'b0);
        check("rst_ram_addr", bus.RAM_ADDR, 12'h000);
        check("rst_mi_in", bus.MI_IN_DATA, 128'h0);
        check("rst_cpu_in", bus.CPU_IN_DATA, 32'h0);
        RESET = 1'b0;

        // Read miss: tag 2, index 1, word 0
        issue(1, 0, 16'h0210, 32'h0, 4'h0);
        serve(0, 12'h021, LINE_A, "miss_a", line);
        wait_ack(lat);
        check("miss_a_data", bus.CPU_IN_DATA, 32'h88888888);

        // Repeat read hits in 3 edges with no RAM traffic
        snap_rd = rd_rise; snap_wr = wr_rise;
        issue(1, 0, 16'h0210, 32'h0, 4'h0);
        wait_ack(lat);
        check("hit_a_latency", lat, 3);
        check("hit_a_data", bus.CPU_IN_DATA, 32'h88888888);
        check("hit_a_no_strobe", rd_rise + wr_rise, snap_rd + snap_wr);

        // Write hit, word 3, low two bytes
        snap_rd = rd_rise; snap_wr = wr_rise;
        issue(0, 1, 16'h021C, 32'h11111111, 4'b0011);
`ifdef CACHE_WRITE_BACK_EN
        wait_ack(lat);
        check("wb_hit_latency", lat, 3);
        check("wb_hit_no_strobe", rd_rise + wr_rise, snap_rd + snap_wr);
`else
        serve(1, 12'h021, 128'h0, "wt_hit", line);
        check("wt_hit_word3", line[127:96], 32'h44441111);
        check("wt_hit_line", line, LINE_AW);
        wait_ack(lat);
        check("wt_hit_one_wr", wr_rise - snap_wr, 1);
`endif
        issue(1, 0, 16'h021C, 32'h0, 4'h0);
        wait_ack(lat);
        check("readback_w3", bus.CPU_IN_DATA, 32'h44441111);

        // Conflict at index 1: tag 3 fills the free way, tag 4 replaces tag 2
        issue(1, 0, 16'h0310, 32'h0, 4'h0);
        serve(0, 12'h031, LINE_B, "miss_b", line);
        wait_ack(lat);
        check("miss_b_data", bus.CPU_IN_DATA, 32'hBBBB0000);
        snap_wr = wr_rise;
        issue(1, 0, 16'h0410, 32'h0, 4'h0);
`ifdef CACHE_WRITE_BACK_EN
        serve(1, 12'h021, 128'h0, "evict_a", line);
        check("evict_a_line", line, LINE_AW);
`endif
        serve(0, 12'h041, LINE_C, "miss_c", line);
        wait_ack(lat);
        check("miss_c_data", bus.CPU_IN_DATA, 32'hCCCC0000);
`ifndef CACHE_WRITE_BACK_EN
        check("miss_c_no_wr", wr_rise, snap_wr);
`endif
        snap_rd = rd_rise;
        issue(1, 0, 16'h0314, 32'h0, 4'h0);
        wait_ack(lat);
        check("hit_b_latency", lat, 3);
        check("hit_b_data", bus.CPU_IN_DATA, 32'hBBBB0001);
        check("hit_b_no_rd", rd_rise, snap_rd);
        issue(1, 0, 16'h0218, 32'h0, 4'h0);
        serve(0, 12'h021, LINE_D, "miss_a2", line);
        wait_ack(lat);
        check("miss_a2_data", bus.CPU_IN_DATA, 32'hDDDD0002);

        // Read request during FILL is ignored
        snap_rd = rd_rise; snap_ack = ack_cnt;
        issue(1, 0, 16'h0520, 32'h0, 4'h0);
        wait_strobe(0, ok);
        check("ovl_strobe", ok, 1'b1);
        check("ovl_ram_addr", bus.RAM_ADDR, 12'h052);
        bus.CPU_ADDR = 16'h0730;
        bus.SIG_CPU_RD = 1'b1;
        @(negedge CLK);
        bus.SIG_CPU_RD = 1'b0;
        finish_serve(0, LINE_E, "ovl");
        wait_ack(lat);
        check("ovl_data", bus.CPU_IN_DATA, 32'hEEEE0000);
        repeat (8) @(negedge CLK);
        check("ovl_one_ack", ack_cnt - snap_ack, 1);
        check("ovl_one_rd", rd_rise - snap_rd, 1);

        // RD and WR together act as a write
        snap_wr = wr_rise;
        issue(1, 1, 16'h0520, 32'hA5A5A5A5, 4'b1111);
`ifndef CACHE_WRITE_BACK_EN
        serve(1, 12'h052, 128'h0, "both_wt", line);
        check("both_wt_line", line, LINE_EW);
`endif
        wait_ack(lat);
`ifdef CACHE_WRITE_BACK_EN
        check("both_wb_no_wr", wr_rise, snap_wr);
`endif
        issue(1, 0, 16'h0520, 32'h0, 4'h0);
        wait_ack(lat);
        check("both_readback", bus.CPU_IN_DATA, 32'hA5A5A5A5);

        // Reset while SIG_RAM_RD is high
        issue(1, 0, 16'h0630, 32'h0, 4'h0);
        wait_strobe(0, ok);
        check("rstmid_strobe", ok, 1'b1);
        snap_ack = ack_cnt;
        RESET = 1'b1;
        @(negedge CLK);
        check("rstmid_rd_low", bus.SIG_RAM_RD, 1'b0);
        RESET = 1'b0;
        repeat (8) @(negedge CLK);
        check("rstmid_no_ack", ack_cnt, snap_ack);
        issue(1, 0, 16'h0630, 32'h0, 4'h0);
        serve(0, 12'h063, LINE_F, "rstmid_miss", line);
        wait_ack(lat);
        check("rstmid_data", bus.CPU_IN_DATA, 32'hFFFF0000);
        issue(1, 0, 16'h0520, 32'h0, 4'h0);
        serve(0, 12'h052, LINE_E, "rstmid_inval", line);
        wait_ack(lat);
        check("rstmid_inval_data", bus.CPU_IN_DATA, 32'hEEEE0000);

        check("never_both_strobes", both_high, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cache_memory_nway.md
# cache_memory_nway

- N-way set-associative successor to the direct-mapped cache controller.
- Sits between the CPU request port and the memory interface (MI).
- Parametrised in data width, set count, associativity and line length; one line moves per MI transfer.
- Write policy is selectable at compile time: write-through/write-allocate or write-back.

## Interface
Parameters:
- CPU_DATA_W, 32, CPU word width in bits (multiple of 8).
- ADDR_W, 16, CPU byte address width.
- INDEX_W, 4, set index bits (2^INDEX_W sets).
- WAYS, 2, associativity; power of two, 1..4.
- LINE_WORDS, 4, CPU words per line; power of two.
- Derived widths:
  - OFFSET_W = log2(LINE_WORDS) + log2(CPU_DATA_W/8).
  - TAG_W = ADDR_W - INDEX_W - OFFSET_W.
  - LINE_W = LINE_WORDS * CPU_DATA_W.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- CLK  in  1  clock, all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CPU_ADDR  in  ADDR_W  {tag, index, offset}; low log2(CPU_DATA_W/8) bits ignored.
- SIG_CPU_RD  in  1  read request pulse.
- SIG_CPU_WR  in  1  write request pulse.
- CPU_OUT_DATA  in  CPU_DATA_W  write data.
- CPU_B_VAL  in  CPU_DATA_W/8  byte enables for writes; ignored on reads.
- MI_OUT_DATA  in  LINE_W  fill line from RAM.
- MI_SIG_RAM_ACK  in  1  RAM completion of current RD/WR.
- ACK  out  1  one-cycle request-complete pulse.
- SIG_RAM_RD  out  1  line read request; held until acknowledged.
- SIG_RAM_WR  out  1  line write request; held until acknowledged.
- RAM_ADDR  out  TAG_W+INDEX_W  line address {tag, index}.
- MI_IN_DATA  out  LINE_W  line written to RAM.
- CPU_IN_DATA  out  CPU_DATA_W  read data; holds until next ACK.

## Operation
- Per way, per set: valid bit, tag, line. Dirty bit is present only in write-back builds.
- Per set: round-robin victim pointer of log2(WAYS) bits.
- Victim selection: lowest-numbered invalid way; otherwise the pointer way. The pointer increments (mod WAYS) on every fill into that set.
- Word select is CPU_ADDR[OFFSET_W-1 : log2(CPU_DATA_W/8)]. Byte i of the selected word is written only when CPU_B_VAL[i]=1.
- FSM states: IDLE, LOOKUP, EVICT, FILL, UPDATE, WTHRU, DONE.
- IDLE: samples SIG_CPU_RD/SIG_CPU_WR and latches address, data and B_VAL. If both are high, the request is a write. Goes to LOOKUP.
- Requests are ignored in every state other than IDLE.
- LOOKUP, all ways compared in parallel:
  - Hit goes to UPDATE.
  - Miss goes to FILL, or to EVICT when the victim is dirty (write-back only).
- EVICT: drives SIG_RAM_WR with victim {tag,index} and line until MI_SIG_RAM_ACK, then FILL.
- FILL:
  - Drives SIG_RAM_RD with the requested {tag,index}.
  - On MI_SIG_RAM_ACK: writes MI_OUT_DATA into the victim way, sets valid, clears dirty, advances the pointer, then UPDATE.
- UPDATE, read: loads CPU_IN_DATA, then DONE.
- UPDATE, write: merges bytes into the line.
  - Write-through: then WTHRU.
  - Write-back: sets dirty, then DONE.
- WTHRU: drives SIG_RAM_WR with the merged full line until MI_SIG_RAM_ACK, then DONE.
- DONE: ACK=1 for one cycle, then IDLE.
- MI_SIG_RAM_ACK outside EVICT/FILL/WTHRU is ignored.

## Timing
- Reset values: ACK=0, SIG_RAM_RD=0, SIG_RAM_WR=0, RAM_ADDR=0, MI_IN_DATA=0, CPU_IN_DATA=0.
- Reset also clears all valid bits, dirty bits and pointers, and puts the FSM in IDLE.
- Reset mid-operation: RAM strobes drop the cycle after the reset edge. Dirty data is discarded, not written back.
- Hit latency: request sampled at edge k; ACK high in the cycle after edge k+3 (IDLE→LOOKUP→UPDATE→DONE). Write-through write hits additionally wait in WTHRU.
- RAM strobes rise the cycle after entering the requesting state. They fall the cycle after MI_SIG_RAM_ACK is sampled high.
- RAM_ADDR and MI_IN_DATA are stable while a strobe is high.
- SIG_RAM_RD and SIG_RAM_WR are never high together.

## Configuration
- CACHE_WRITE_BACK_EN defined:
  - Dirty bits present; EVICT state reachable.
  - Write hits cause no RAM traffic.
  - Misses evicting dirty lines issue write then read.
- CACHE_WRITE_BACK_EN undefined:
  - Write-through with write-allocate; no dirty storage; EVICT unreachable.
  - Every write ends with a full-line SIG_RAM_WR.

## Test plan
Defaults for all scenarios: WAYS=2, LINE_WORDS=4, INDEX_W=4, ADDR_W=16, so TAG_W=8.

- Read miss: tag 2, index 1, offset 0; MI_OUT_DATA={44444444,33333333,22222222,88888888}, with word 0 = 88888888 (LSB word).
  - Expect SIG_RAM_RD with RAM_ADDR=0x021, held until ACK.
  - Expect ACK with CPU_IN_DATA=0x88888888.
  - Repeating the read gives ACK 3 edges after sampling, with no RAM strobe.
- Write hit: offset 0xC, B_VAL=0011, data 0x11111111.
  - Readback of word 3 gives 0x44441111.
  - Write-through: one SIG_RAM_WR, MI_IN_DATA[127:96]=0x44441111.
  - Write-back: no strobe.
- Conflict: read tags 2, 3, 4 at index 1.
  - Tag 4 replaces the tag-2 way.
  - Tag 3 then hits; tag 2 misses.
- Write-back dirty eviction: dirty tag 2, plus tags 3 and 4 at index 1.
  - Expect SIG_RAM_WR with RAM_ADDR=0x021 and the dirty line, then SIG_RAM_RD with 0x041.
- Reset while SIG_RAM_RD is high.
  - Strobe is low the next cycle; no ACK.
  - Subsequent read of the same address misses.
- Overlapping requests:
  - SIG_CPU_RD during FILL is ignored; exactly one ACK.
  - RD and WR asserted together execute as a write.
